// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate controller: FSM encoding and datapath width.
package accum_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_gatelevel32.sv
// 32-bit ripple-carry adder built from gate primitives; carry-in is tied to zero.
module ripple_carry_gatelevel32
  import accum_pkg::*;
(
  output logic [DATA_W-1:0] s,
  output logic              cout,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b
);

  wire [DATA_W:0]   c;
  wire [DATA_W-1:0] sum_w;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    wire p, g, t;
    xor u_p (p, a[i], b[i]);
    xor u_s (sum_w[i], p, c[i]);
    and u_g (g, a[i], b[i]);
    and u_t (t, p, c[i]);
    or  u_c (c[i+1], g, t);
  end

  assign s    = sum_w;
  assign cout = c[DATA_W];

endmodule

// File: rtl/accum_ctrl32.sv
// Accumulates a requested number of 32-bit operands over a valid/ready stream
// and presents the wrapped sum plus a sticky carry-out flag until accepted.
module accum_ctrl32
  import accum_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              ovf,
  output logic              busy
);

  localparam logic [CNT_W-1:0] REM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] add_s;
  logic              add_cout;
  logic              accept_start;
  logic              xfer;

  ripple_carry_gatelevel32 u_add (
    .s    (add_s),
    .cout (add_cout),
    .a    (acc),
    .b    (in_data)
  );

  assign accept_start = (state == IDLE) && start;
  assign xfer         = (state == ACCUM) && in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (accept_start) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= count;
    end else if (xfer) begin
      acc       <= add_s;
      ovf       <= ovf | add_cout;
      remaining <= remaining - REM_ONE;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_nx = (count == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        // Handshake ready depends on state only, never on in_valid.
        in_ready = 1'b1;
        if (in_valid && (remaining == REM_ONE)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sum = acc;

endmodule

// File: tb/tb_accum_ctrl32.sv
// Directed self-checking bench for accum_ctrl32 with hand-computed expectations.
module tb_accum_ctrl32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  accum_ctrl32 #(.CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    // Three back-to-back operands, result accepted immediately.
    out_ready = 1'b1;
    start = 1'b1; count = 5'd3;
    tick();
    start = 1'b0;
    check("c3_busy", busy, 1);
    check("c3_in_ready", in_ready, 1);
    check("c3_out_valid_early", out_valid, 0);
    in_valid = 1'b1; in_data = 32'h1; tick();
    in_data = 32'h2; tick();
    check("c3_partial", sum, 32'h3);
    in_data = 32'h3; tick();
    in_valid = 1'b0;
    check("c3_out_valid", out_valid, 1);
    check("c3_sum", sum, 32'h6);
    check("c3_ovf", ovf, 0);
    check("c3_in_ready_done", in_ready, 0);
    tick();
    check("c3_idle", busy, 0);
    check("c3_sum_held", sum, 32'h6);

    // Wrap with carry-out, then a fresh run clears the sticky flag.
    start = 1'b1; count = 5'd2; tick();
    start = 1'b0;
    check("wrap_cleared", sum, 0);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; tick();
    check("wrap_no_carry_yet", ovf, 0);
    in_data = 32'h2; tick();
    in_valid = 1'b0;
    check("wrap_sum", sum, 32'h1);
    check("wrap_ovf", ovf, 1);
    check("wrap_out_valid", out_valid, 1);
    tick();
    check("wrap_ovf_idle", ovf, 1);
    start = 1'b1; count = 5'd1; tick();
    start = 1'b0;
    check("fresh_ovf_clear", ovf, 0);
    in_valid = 1'b1; in_data = 32'h10; tick();
    in_valid = 1'b0;
    check("fresh_sum", sum, 32'h10);
    check("fresh_ovf", ovf, 0);
    check("fresh_out_valid", out_valid, 1);
    tick();

    // Gaps in in_valid must not consume operands.
    start = 1'b1; count = 5'd2; tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h0080_0800; tick();
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF; tick();
    tick();
    check("gap_sum_hold", sum, 32'h0080_0800);
    check("gap_in_ready", in_ready, 1);
    check("gap_out_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 32'h0002_0000; tick();
    in_valid = 1'b0;
    check("gap_sum", sum, 32'h0082_0800);
    check("gap_out_valid_done", out_valid, 1);
    tick();

    // count=0 goes straight to DONE with a cleared result.
    out_ready = 1'b0;
    start = 1'b1; count = 5'd0; tick();
    start = 1'b0;
    check("zero_out_valid", out_valid, 1);
    check("zero_in_ready", in_ready, 0);
    check("zero_sum", sum, 0);
    check("zero_ovf", ovf, 0);
    out_ready = 1'b1; tick();
    check("zero_idle", busy, 0);

    // Backpressure on the result; start pulses in ACCUM and DONE are ignored.
    out_ready = 1'b0;
    start = 1'b1; count = 5'd1; tick();
    count = 5'd5; tick();
    check("bp_accum_ignore_start", in_ready, 1);
    check("bp_accum_sum", sum, 0);
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h55; tick();
    in_valid = 1'b0;
    start = 1'b1; count = 5'd3;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", sum, 32'h55);
      tick();
    end
    out_ready = 1'b1; tick();
    start = 1'b0;
    check("bp_exit_idle", busy, 0);
    tick();
    check("bp_exit_start_ignored", busy, 0);
    check("bp_exit_sum", sum, 32'h55);

    // Asynchronous reset mid-accumulation discards the partial result.
    out_ready = 1'b0;
    start = 1'b1; count = 5'd3; tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h100; tick();
    check("mid_partial", sum, 32'h100);
    in_data = 32'h200;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", sum, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    #1 rst_n = 1'b1;
    tick();
    check("mid_release_sum", sum, 0);
    check("mid_release_busy", busy, 0);
    in_valid = 1'b0;
    start = 1'b1; count = 5'd1; tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h7; tick();
    in_valid = 1'b0;
    check("post_rst_sum", sum, 32'h7);
    check("post_rst_out_valid", out_valid, 1);
    out_ready = 1'b1; tick();
    check("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_ctrl32.md
ACCUM_CTRL32 -- requirements
Module: accum_ctrl32

Interface
REQ-001 The block SHALL have parameter CNT_W, default 5, width of the operand-count field.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a new accumulation; sampled only in IDLE.
REQ-005 count  input  CNT_W  number of operands to accumulate, sampled with start.
REQ-006 in_valid  input  1  upstream operand present.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_data  input  32  operand.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 sum  output  32  accumulated result, modulo 2^32.
REQ-012 ovf  output  1  sticky OR of every adder carry-out during the current accumulation.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-015 In IDLE, start=1 with count!=0 SHALL clear acc and ovf, load remaining=count, and move to ACCUM next cycle.
REQ-016 In IDLE, start=1 with count=0 SHALL clear acc and ovf and move directly to DONE (result 0, ovf 0).
REQ-017 start SHALL be ignored in ACCUM and DONE; no state or data change results.
REQ-018 in_ready SHALL be 1 only in ACCUM, derived from state alone (no combinational path from in_valid).
REQ-019 A transfer occurs on a rising edge where in_valid=1 and in_ready=1; then acc <= acc + in_data (carry-in 0), ovf <= ovf | carry-out, remaining <= remaining-1.
REQ-020 in_valid=0 in ACCUM SHALL hold acc, ovf, remaining unchanged for any number of cycles.
REQ-021 The transfer with remaining=1 SHALL move the FSM to DONE; out_valid SHALL be 1 the cycle after the last accepted operand (latency 1).
REQ-022 In DONE, out_valid=1 and sum=acc, ovf stable, held until out_ready=1; that edge returns the FSM to IDLE.
REQ-023 out_ready SHALL have no effect outside DONE.
REQ-024 sum SHALL equal acc in every state; addition wraps modulo 2^32 with overflow reported only via ovf.
REQ-025 A start sampled in the same cycle DONE exits to IDLE SHALL be ignored (start only accepted while already in IDLE).

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, acc=0, ovf=0, remaining=0, giving in_ready=0, out_valid=0, busy=0, sum=0.
REQ-027 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial/pending result; no operand is consumed on the release edge.

Structure
REQ-028 State encoding (IDLE/ACCUM/DONE) and the 32-bit data width constant SHALL reside in a shared package, accum_pkg.
REQ-029 The 32-bit addition SHALL be performed by one instance of the existing ripple_carry_gatelevel32 (ports s, cout, a, b) with a=acc, b=in_data; no behavioural '+' on the datapath.
REQ-030 acc, ovf, remaining and state SHALL be the only sequential elements.

Verification
REQ-031 count=3, operands 0x00000001, 0x00000002, 0x00000003 back-to-back, out_ready=1 -> out_valid one cycle after third transfer, sum=0x00000006, ovf=0.
REQ-032 count=2, operands 0xFFFFFFFF, 0x00000002 -> sum=0x00000001, ovf=1; next accumulation count=1, operand 0x10 -> sum=0x00000010, ovf=0.
REQ-033 count=2, in_valid toggled 1,0,0,1 with operands 0x00800800, 0x00020000 -> only two transfers, sum=0x00820800.
REQ-034 count=0 start -> DONE next cycle, sum=0, ovf=0, in_ready never 1.
REQ-035 Result held with out_ready=0 for 5 cycles plus start pulses in ACCUM and DONE -> sum/out_valid stable, starts ignored, IDLE after out_ready=1.
REQ-036 rst_n pulsed low after one of three operands accepted -> all outputs 0 immediately; fresh count=1 operand 0x7 run gives sum=0x00000007.
